// File: rtl/camera_pkg.sv
// Frame geometry and controller state encoding shared by the capture block.
package camera_pkg;

  localparam int LINE_PIXELS     = 160;
  localparam int X0              = 32;
  localparam int Y0              = 12;
  localparam int WIN_W           = 96;
  localparam int WIN_H           = 96;
  localparam int BYTES_PER_FRAME = WIN_W * WIN_H;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SYNC    = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer for one asynchronous camera line, plus single-cycle
// rise/fall pulses derived from the synchronized level.
module sync_edge (
  input  logic Clk,
  input  logic Rst,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/camera_capture.sv
// Camera capture: free-running sensor master clock, DVP byte sampling and
// writes of the Y bytes inside a fixed crop window to a frame RAM.
//
// state   | meaning
// IDLE    | waiting for i_Arm
// SYNC    | armed, waiting for the start of the next frame (VS fall)
// CAPTURE | sampling lines, writing window pixels
// DONE    | one-cycle frame-done pulse with error qualifier
module camera_capture #(
  parameter int XLK_HALF    = 4,
  parameter int LINE_PIXELS = camera_pkg::LINE_PIXELS,
  parameter int X0          = camera_pkg::X0,
  parameter int Y0          = camera_pkg::Y0,
  parameter int WIN_W       = camera_pkg::WIN_W,
  parameter int WIN_H       = camera_pkg::WIN_H
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        i_PLK,
  input  logic        i_VS,
  input  logic        i_HS,
  input  logic [7:0]  i_D,
  input  logic        i_Arm,
  output logic        o_XLK,
  output logic [7:0]  o_Data,
  output logic [14:0] o_Addr,
  output logic        o_We,
  output logic        o_Busy,
  output logic        o_Frame_Done,
  output logic        o_Frame_Error
);
  import camera_pkg::*;

  localparam int              DW           = (XLK_HALF > 1) ? $clog2(XLK_HALF) : 1;
  localparam logic [DW-1:0]   DIV_TC       = DW'(XLK_HALF - 1);
  localparam logic [8:0]      ROW_LO       = 9'(Y0);
  localparam logic [8:0]      ROW_HI       = 9'(Y0 + WIN_H);
  localparam logic [8:0]      ROW_MAX      = 9'd511;
  localparam logic [7:0]      COL_LO       = 8'(X0);
  localparam logic [7:0]      COL_HI       = 8'(X0 + WIN_W);
  localparam logic [7:0]      COL_MAX      = 8'(LINE_PIXELS - 1);
  localparam logic [14:0]     WIN_W_A      = 15'(WIN_W);
  localparam logic [14:0]     FRAME_WRITES = 15'(WIN_W * WIN_H);

  logic [DW-1:0] div_q;
  logic          xlk_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      div_q <= '0;
      xlk_q <= 1'b0;
    end else if (div_q == DIV_TC) begin
      div_q <= '0;
      xlk_q <= ~xlk_q;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  assign o_XLK = xlk_q;

  logic plk_rise, plk_q_unused, plk_fall_unused;
  logic vs_rise, vs_fall, vs_q_unused;
  logic hs_lvl, hs_fall, hs_rise_unused;

  sync_edge u_sync_plk (.Clk(Clk), .Rst(Rst), .d_i(i_PLK), .q_o(plk_q_unused),
                        .rise_o(plk_rise), .fall_o(plk_fall_unused));
  sync_edge u_sync_vs  (.Clk(Clk), .Rst(Rst), .d_i(i_VS), .q_o(vs_q_unused),
                        .rise_o(vs_rise), .fall_o(vs_fall));
  sync_edge u_sync_hs  (.Clk(Clk), .Rst(Rst), .d_i(i_HS), .q_o(hs_lvl),
                        .rise_o(hs_rise_unused), .fall_o(hs_fall));

  // Data rides the same two-stage delay as PLK so it lines up with plk_rise.
  logic [7:0] d_meta_q;
  logic [7:0] d_sync_q;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      d_meta_q <= '0;
      d_sync_q <= '0;
    end else begin
      d_meta_q <= i_D;
      d_sync_q <= d_meta_q;
    end
  end

  state_e      state_q;
  logic [8:0]  row_q;
  logic [7:0]  col_q;
  logic        phase_q;
  logic [14:0] wr_cnt_q;
  logic [14:0] wr_cnt_d;
  logic [14:0] addr_d;
  logic        in_win;
  logic        we_d;

  always_comb begin
    in_win   = (row_q >= ROW_LO) && (row_q < ROW_HI) && (col_q >= COL_LO) && (col_q < COL_HI);
    we_d     = (state_q == CAPTURE) && plk_rise && hs_lvl && !phase_q && in_win;
    addr_d   = 15'(row_q - ROW_LO) * WIN_W_A + 15'(col_q - COL_LO);
    wr_cnt_d = we_d ? wr_cnt_q + 15'd1 : wr_cnt_q;
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q       <= IDLE;
      row_q         <= '0;
      col_q         <= '0;
      phase_q       <= 1'b0;
      wr_cnt_q      <= '0;
      o_We          <= 1'b0;
      o_Data        <= '0;
      o_Addr        <= '0;
      o_Busy        <= 1'b0;
      o_Frame_Done  <= 1'b0;
      o_Frame_Error <= 1'b0;
    end else begin
      o_We          <= we_d;
      o_Frame_Done  <= 1'b0;
      o_Frame_Error <= 1'b0;
      wr_cnt_q      <= wr_cnt_d;
      if (we_d) begin
        o_Data <= d_sync_q;
        o_Addr <= addr_d;
      end
      case (state_q)
        IDLE: begin
          if (i_Arm) begin
            state_q <= SYNC;
            o_Busy  <= 1'b1;
          end
        end
        SYNC: begin
          if (vs_fall) begin
            state_q  <= CAPTURE;
            row_q    <= '0;
            col_q    <= '0;
            phase_q  <= 1'b0;
            wr_cnt_q <= '0;
          end
        end
        CAPTURE: begin
          if (plk_rise && hs_lvl) begin
            phase_q <= ~phase_q;
            if (phase_q && (col_q != COL_MAX)) col_q <= col_q + 8'd1;
          end
          if (hs_fall) begin
            if (row_q != ROW_MAX) row_q <= row_q + 9'd1;
            col_q   <= '0;
            phase_q <= 1'b0;
          end
          // Error uses the count including a write issued in this same cycle.
          if (vs_rise) begin
            state_q       <= DONE;
            o_Frame_Done  <= 1'b1;
            o_Frame_Error <= (wr_cnt_d != FRAME_WRITES);
          end
        end
        DONE: begin
          state_q <= IDLE;
          o_Busy  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          o_Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
